// File: rtl/cfu_fifo_if.sv
// Handshake bundle between the CFU request producer, the CFU datapath and the
// buffering FIFO; the FIFO binds to the slave modport.
interface cfu_fifo_interface #(
    parameter int DATA_WIDTH = 42
);
    logic                  push;
    logic                  potential_push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;

    modport master (
        output push, potential_push, pop, data_in,
        input  data_out, valid, full
    );

    modport slave (
        input  push, potential_push, pop, data_in,
        output data_out, valid, full
    );
endinterface

// File: rtl/cfu_fifo.sv
// First-word-fall-through circular buffer for CFU words, with speculative
// (potential_push) slot writes and sticky overflow/underflow flags.
module cfu_fifo #(
    parameter int DATA_WIDTH = 42,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    cfu_fifo_interface.slave  fifo,
    output logic              overflow,
    output logic              underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_w, valid_w, push_ok, pop_ok, wr_en;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        full_w      = (count_q == CNT_W'(DEPTH));
        valid_w     = (count_q != '0);
        push_ok     = fifo.push & ~full_w;
        pop_ok      = fifo.pop & valid_w;
        wr_en       = (fifo.potential_push | fifo.push) & ~full_w & rst;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = overflow_q  | (fifo.push & full_w);
        underflow_d = underflow_q | (fifo.pop & ~valid_w);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; stale contents are hidden by count_q == 0.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= fifo.data_in;
    end

    assign fifo.data_out = mem_q[rd_ptr_q];
    assign fifo.valid    = valid_w;
    assign fifo.full     = full_w;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
endmodule

// File: tb/tb_cfu_fifo.sv
// Directed bench for cfu_fifo: stimulus enqueues expected words into a
// scoreboard; an independent monitor compares every word the DUT pops.
module tb_cfu_fifo;
    localparam int DW    = 42;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic overflow, underflow;

    cfu_fifo_interface #(.DATA_WIDTH(DW)) fifo_if ();

    cfu_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (fifo_if),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q [$];
    int            m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: at the falling edge, a pop that the DUT will honour must present
    // the oldest outstanding scoreboard word.
    always @(negedge clk) begin
        if (rst && fifo_if.pop && fifo_if.valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected no output", fifo_if.data_out);
            end else begin
                check("sb_data", 64'(fifo_if.data_out), 64'(exp_q.pop_front()));
            end
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic push, input logic ppush, input logic pop, input logic [DW-1:0] d);
        logic push_ok, pop_ok;
        fifo_if.push           = push;
        fifo_if.potential_push = ppush;
        fifo_if.pop            = pop;
        fifo_if.data_in        = d;
        push_ok = push && (m_cnt < DEPTH);
        pop_ok  = pop && (m_cnt > 0);
        if (push_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        fifo_if.push           = 1'b0;
        fifo_if.potential_push = 1'b0;
        fifo_if.pop            = 1'b0;
    endtask

    task automatic reset_cycle(input logic push, input logic [DW-1:0] d);
        rst                    = 1'b0;
        fifo_if.push           = push;
        fifo_if.potential_push = 1'b0;
        fifo_if.pop            = 1'b0;
        fifo_if.data_in        = d;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        fifo_if.push = 1'b0;
        exp_q.delete();
        m_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fifo_if.push           = 1'b0;
        fifo_if.potential_push = 1'b0;
        fifo_if.pop            = 1'b0;
        fifo_if.data_in        = '0;
        @(posedge clk);
        reset_cycle(1'b0, '0);
        check("rst_valid", 64'(fifo_if.valid), 64'd0);
        check("rst_full", 64'(fifo_if.full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);

        // Basic FWFT ordering
        cyc(1, 0, 0, 42'h1);
        check("fwft_valid", 64'(fifo_if.valid), 64'd1);
        check("fwft_data", 64'(fifo_if.data_out), 64'h1);
        cyc(1, 0, 0, 42'h2);
        cyc(1, 0, 0, 42'h3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, '0);
        check("drain_valid", 64'(fifo_if.valid), 64'd0);

        // Fill, overflow, pop from full
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 42'hA0 + 42'(i));
        check("full_set", 64'(fifo_if.full), 64'd1);
        check("full_no_ovf", 64'(overflow), 64'd0);
        cyc(1, 0, 0, 42'hAA);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_full", 64'(fifo_if.full), 64'd1);
        check("ovf_head", 64'(fifo_if.data_out), 64'hA0);
        cyc(0, 0, 1, '0);
        check("full_clear", 64'(fifo_if.full), 64'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, '0);
        check("ovf_drain_valid", 64'(fifo_if.valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Speculative writes: only the committed value appears
        cyc(0, 1, 0, 42'h10);
        cyc(0, 1, 0, 42'h11);
        cyc(0, 1, 0, 42'h12);
        check("pp_no_valid", 64'(fifo_if.valid), 64'd0);
        cyc(1, 0, 0, 42'h13);
        check("pp_valid", 64'(fifo_if.valid), 64'd1);
        check("pp_data", 64'(fifo_if.data_out), 64'h13);
        cyc(0, 0, 1, '0);
        check("pp_underflow", 64'(underflow), 64'd0);

        // Steady-state push+pop across pointer wraps
        cyc(1, 0, 0, 42'h20);
        cyc(1, 0, 0, 42'h21);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 42'h22 + 42'(i));
        check("pp2_full", 64'(fifo_if.full), 64'd0);
        check("pp2_valid", 64'(fifo_if.valid), 64'd1);
        cyc(0, 0, 1, '0);
        check("pp2_one_left", 64'(fifo_if.valid), 64'd1);
        cyc(0, 0, 1, '0);
        check("pp2_empty", 64'(fifo_if.valid), 64'd0);

        // Underflow
        cyc(0, 0, 1, '0);
        check("udf_set", 64'(underflow), 64'd1);
        check("udf_valid", 64'(fifo_if.valid), 64'd0);
        cyc(1, 0, 1, 42'h5);
        check("udf_push_valid", 64'(fifo_if.valid), 64'd1);
        check("udf_push_data", 64'(fifo_if.data_out), 64'h5);
        cyc(0, 0, 1, '0);
        check("udf_sticky", 64'(underflow), 64'd1);

        // Reset overrides a concurrent push
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 42'h30 + 42'(i));
        reset_cycle(1'b1, 42'h99);
        check("rst2_valid", 64'(fifo_if.valid), 64'd0);
        check("rst2_full", 64'(fifo_if.full), 64'd0);
        check("rst2_overflow", 64'(overflow), 64'd0);
        check("rst2_underflow", 64'(underflow), 64'd0);
        cyc(1, 0, 0, 42'h7);
        check("rst2_data", 64'(fifo_if.data_out), 64'h7);
        cyc(0, 0, 1, '0);
        check("end_valid", 64'(fifo_if.valid), 64'd0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
